// File: rtl/fifo_arb_pkg.sv
// Shared types, default sizes and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

  // Arbiter FSM: idle (arbitrating) or granting one producer a burst
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 3;
  localparam int BURST_MAX_DEF = 4;

  // Widest requester vector supported by the helpers below
  localparam int NREQ_MAX = 8;

  // One-hot decode of a requester index; callers size-cast to their width
  function automatic logic [NREQ_MAX-1:0] onehot(input logic [2:0] idx);
    logic [NREQ_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning
// last+1, last+2, ... modulo NREQ. Kept generic so the read-side
// scheduler can reuse it.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    valid
);

  localparam int LW = $clog2(NREQ);

  // w_cand[k] is the index examined at priority position k (0 = highest)
  logic [LW-1:0]   w_cand [NREQ];
  logic [NREQ-1:0] w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      localparam int OFS = gi + 1;
      assign w_cand[gi] = LW'((int'(last) + OFS) % NREQ);
      assign w_hit[gi]  = req[w_cand[gi]];
    end
  endgenerate

  // Priority select: scanning from lowest priority up lets the highest win
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        winner = w_cand[k];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port among NREQ
// producers. One producer owns the port for at most BURST_MAX beats;
// fifo_full stalls the owner without releasing it.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  input  logic               fifo_full,
  output logic               fifo_wen,
  output logic [DW-1:0]      fifo_din,
  output logic               busy
);

  localparam int         LW         = $clog2(NREQ);
  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX);

  arb_state_t      r_state,    w_state_next;
  logic [LW-1:0]   r_owner,    w_owner_next;
  logic [LW-1:0]   r_last,     w_last_next;
  logic [3:0]      r_beat_cnt, w_beat_cnt_next;
  logic [NREQ-1:0] r_gnt,      w_gnt_next;

  logic [LW-1:0]   w_winner;
  logic            w_win_valid;
  logic            w_granting;
  logic            w_beat_ok;
  logic [DW-1:0]   w_din_arr [NREQ];

  // Unpack the flat producer data bus into one word per requester
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_din
      assign w_din_arr[gi] = din[gi*DW +: DW];
    end
  endgenerate

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req    (req),
    .last   (r_last),
    .winner (w_winner),
    .valid  (w_win_valid)
  );

  // A beat is accepted only from the owner and only while the FIFO has room
  assign w_granting = (r_state == ST_GRANT);
  assign w_beat_ok  = w_granting && req[r_owner] && !fifo_full;

  assign fifo_wen = w_beat_ok;
  assign fifo_din = w_granting ? w_din_arr[r_owner] : '0;
  assign ack      = w_beat_ok ? NREQ'(onehot(3'(r_owner))) : '0;
  assign gnt      = r_gnt;
  assign busy     = w_granting;

  // State register; reset leaves last = NREQ-1 so requester 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_last     <= LW'(NREQ - 1);
      r_beat_cnt <= '0;
      r_gnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_last     <= w_last_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_gnt      <= w_gnt_next;
    end
  end

  // Next-state: arbitrate in IDLE, count beats / release in GRANT
  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
    w_last_next     = r_last;
    w_beat_cnt_next = r_beat_cnt;
    w_gnt_next      = r_gnt;
    case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          w_state_next    = ST_GRANT;
          w_owner_next    = w_winner;
          w_last_next     = w_winner;
          w_beat_cnt_next = '0;
          w_gnt_next      = NREQ'(onehot(3'(w_winner)));
        end
      end
      ST_GRANT: begin
        if (!req[r_owner]) begin
          // Owner has nothing more to send: give the port up
          w_state_next    = ST_IDLE;
          w_gnt_next      = '0;
          w_beat_cnt_next = '0;
        end else if (!fifo_full) begin
          if (r_beat_cnt + 4'd1 == BURST_LAST) begin
            w_state_next    = ST_IDLE;
            w_gnt_next      = '0;
            w_beat_cnt_next = '0;
          end else begin
            w_beat_cnt_next = r_beat_cnt + 4'd1;
          end
        end
        // fifo_full with a pending request: hold everything (stall)
      end
      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

endmodule
